// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package ram_arb_pkg;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  localparam int unsigned M0    = 0;
  localparam int unsigned M1    = 1;
  localparam int unsigned NPORT = 2;

endpackage

// File: rtl/gnrl_rr_arb2.sv
// Two-requester round-robin arbiter; prio names the winner when both request.
module gnrl_rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio_q ? 2'b10 : 2'b01;
    end
  end

  // Priority passes to the other requester after every grant.
  always_comb begin
    prio_d = prio_q;
    if (gnt[M0]) begin
      prio_d = 1'b1;
    end else if (gnt[M1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between fetch (m0) and load/store (m1) masters,
// with a one-entry response register per port.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned MW = 4,
  parameter int unsigned AB = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_req_addr,
  input  logic          m0_req_we,
  input  logic [MW-1:0] m0_req_wem,
  input  logic [DW-1:0] m0_req_wdata,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_rdata,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic [AW-1:0] m1_req_addr,
  input  logic          m1_req_we,
  input  logic [MW-1:0] m1_req_wem,
  input  logic [DW-1:0] m1_req_wdata,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [MW-1:0] ram_wem,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [NPORT-1:0] req_valid;
  logic [NPORT-1:0] req_we;
  logic [AW-1:0]    req_addr  [NPORT];
  logic [MW-1:0]    req_wem   [NPORT];
  logic [DW-1:0]    req_wdata [NPORT];
  logic [NPORT-1:0] rsp_ready;
  logic [NPORT-1:0] rsp_valid;
  logic [NPORT-1:0] elig;
  logic [NPORT-1:0] gnt;
  rsp_state_e       slot_q    [NPORT];
  rsp_state_e       slot_d    [NPORT];
  logic [DW-1:0]    rdata_q   [NPORT];
  logic             addr_lsb_unused;

  assign req_valid[M0] = m0_req_valid;
  assign req_valid[M1] = m1_req_valid;
  assign req_we[M0]    = m0_req_we;
  assign req_we[M1]    = m1_req_we;
  assign req_addr[M0]  = m0_req_addr;
  assign req_addr[M1]  = m1_req_addr;
  assign req_wem[M0]   = m0_req_wem;
  assign req_wem[M1]   = m1_req_wem;
  assign req_wdata[M0] = m0_req_wdata;
  assign req_wdata[M1] = m1_req_wdata;
  assign rsp_ready[M0] = m0_rsp_ready;
  assign rsp_ready[M1] = m1_rsp_ready;

  // Byte lanes are selected by wem, so the word-offset bits carry no information.
  assign addr_lsb_unused = ^{m0_req_addr[AB-1:0], m1_req_addr[AB-1:0]};

  // Eligible when requesting and the response slot is free or draining now; never during reset.
  assign elig = req_valid & (~rsp_valid | rsp_ready) & {NPORT{rst_n}};

  gnrl_rr_arb2 u_rr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (elig),
    .gnt   (gnt)
  );

  assign m0_req_ready = gnt[M0];
  assign m1_req_ready = gnt[M1];

  always_comb begin
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    ram_addr = '0;
    ram_din  = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (gnt[k]) begin
        ram_cs   = 1'b1;
        ram_we   = req_we[k];
        ram_wem  = req_we[k] ? req_wem[k] : '0;
        ram_addr = {AB'(0), req_addr[k][AW-1:AB]};
        ram_din  = req_wdata[k];
      end
    end
  end

  // Response slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        slot_q[k] <= RSP_EMPTY;
      end
    end else begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  // A new grant always refills the slot, even while the old response drains.
  always_comb begin
    for (int unsigned k = 0; k < NPORT; k++) begin
      slot_d[k] = slot_q[k];
      case (slot_q[k])
        RSP_EMPTY: if (gnt[k]) slot_d[k] = RSP_FULL;
        RSP_FULL: begin
          if (gnt[k]) begin
            slot_d[k] = RSP_FULL;
          end else if (rsp_ready[k]) begin
            slot_d[k] = RSP_EMPTY;
          end
        end
        default: slot_d[k] = RSP_EMPTY;
      endcase
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NPORT; k++) begin
      rsp_valid[k] = (slot_q[k] == RSP_FULL);
    end
  end

  // Writes return an all-zero acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        rdata_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NPORT; k++) begin
        if (gnt[k]) begin
          rdata_q[k] <= req_we[k] ? '0 : ram_dout;
        end
      end
    end
  end

  assign m0_rsp_valid = rsp_valid[M0];
  assign m1_rsp_valid = rsp_valid[M1];
  assign m0_rsp_rdata = rdata_q[M0];
  assign m1_rsp_rdata = rdata_q[M1];

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v   [2];
  logic        rdy [2];
  logic [31:0] ad  [2];
  logic        we  [2];
  logic [3:0]  wm  [2];
  logic [31:0] wd  [2];
  logic        rv  [2];
  logic        rr  [2];
  logic [31:0] rd  [2];
  logic        ram_cs;
  logic        ram_we;
  logic [3:0]  ram_wem;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic [31:0] mem [256];
  logic        clr;
  logic        pl_en;
  logic [7:0]  pl_idx;
  logic [31:0] pl_dat;

  int total = 0;
  int bad   = 0;

  bit          mf   [2];
  logic [31:0] md   [2];
  bit          mprio;
  logic [31:0] refm [256];

  typedef struct {
    logic       v0;
    logic       v1;
    logic       rr0;
    logic       rr1;
    logic [1:0] gnt;
  } vec_t;

  vec_t tbl [9];

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_valid (v[0]),
    .m0_req_ready (rdy[0]),
    .m0_req_addr  (ad[0]),
    .m0_req_we    (we[0]),
    .m0_req_wem   (wm[0]),
    .m0_req_wdata (wd[0]),
    .m0_rsp_valid (rv[0]),
    .m0_rsp_ready (rr[0]),
    .m0_rsp_rdata (rd[0]),
    .m1_req_valid (v[1]),
    .m1_req_ready (rdy[1]),
    .m1_req_addr  (ad[1]),
    .m1_req_we    (we[1]),
    .m1_req_wem   (wm[1]),
    .m1_req_wdata (wd[1]),
    .m1_rsp_valid (rv[1]),
    .m1_rsp_ready (rr[1]),
    .m1_rsp_rdata (rd[1]),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_wem      (ram_wem),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // Behavioural single-port RAM with combinational read.
  assign ram_dout = mem[ram_addr[7:0]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (pl_en) begin
      mem[pl_idx] <= pl_dat;
    end else if (ram_cs && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_wem[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_din[8*b +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mf[k] = 1'b0;
      md[k] = '0;
    end
    mprio = 1'b0;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      v[k]  = 1'b0;
      we[k] = 1'b0;
      ad[k] = '0;
      wm[k] = '0;
      wd[k] = '0;
      rr[k] = 1'b1;
    end
  endtask

  task automatic set_req(input int k, input logic w, input logic [31:0] a,
                         input logic [3:0] m, input logic [31:0] d);
    v[k]  = 1'b1;
    we[k] = w;
    ad[k] = a;
    wm[k] = m;
    wd[k] = d;
  endtask

  // One clock cycle: check every output against the model, then advance the model.
  task automatic step();
    int gi;
    bit e0;
    bit e1;
    int wi;
    #1;
    e0 = rst_n && v[0] && (!mf[0] || rr[0]);
    e1 = rst_n && v[1] && (!mf[1] || rr[1]);
    if (e0 && e1) gi = mprio ? 1 : 0;
    else if (e0) gi = 0;
    else if (e1) gi = 1;
    else gi = -1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m%0d_rsp_valid", k), 32'(rv[k]), 32'(mf[k]));
      chk($sformatf("m%0d_rsp_rdata", k), rd[k], md[k]);
      chk($sformatf("m%0d_req_ready", k), 32'(rdy[k]), 32'(gi == k));
    end
    chk("ram_cs", 32'(ram_cs), 32'(gi >= 0));
    chk("ram_we", 32'(ram_we), (gi >= 0) ? 32'(we[gi]) : 32'd0);
    chk("ram_wem", 32'(ram_wem), (gi >= 0 && we[gi]) ? 32'(wm[gi]) : 32'd0);
    chk("ram_addr", ram_addr, (gi >= 0) ? (ad[gi] >> 2) : 32'd0);
    chk("ram_din", ram_din, (gi >= 0) ? wd[gi] : 32'd0);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k != gi && mf[k] && rr[k]) mf[k] = 1'b0;
    end
    if (gi >= 0) begin
      wi = int'(ad[gi] >> 2) % 256;
      if (we[gi]) begin
        md[gi] = '0;
        for (int b = 0; b < 4; b++) begin
          if (wm[gi][b]) refm[wi][8*b +: 8] = wd[gi][8*b +: 8];
        end
      end else begin
        md[gi] = refm[wi];
      end
      mf[gi] = 1'b1;
      mprio  = (gi == 0);
    end
    @(negedge clk);
  endtask

  task automatic preload(input int idx, input logic [31:0] dat);
    pl_en  = 1'b1;
    pl_idx = 8'(idx);
    pl_dat = dat;
    @(posedge clk);
    @(negedge clk);
    pl_en = 1'b0;
    refm[idx] = dat;
  endtask

  // Reset with a master requesting: nothing may reach the RAM, outputs at reset values.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    idle();
    set_req(0, 1'b0, 32'h14, 4'h0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b10};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b01};

    rst_n = 1'b0;
    clr = 1'b1;
    pl_en = 1'b0;
    pl_idx = '0;
    pl_dat = '0;
    idle();
    model_reset();
    for (int i = 0; i < 256; i++) refm[i] = '0;
    @(negedge clk);
    clr = 1'b0;
    preload(5, 32'hDEADBEEF);
    preload(2, 32'h11223344);
    do_reset();

    // Single read of word 5.
    set_req(0, 1'b0, 32'h14, 4'hF, 32'h0);
    #1;
    chk("single_rd_addr", ram_addr, 32'd5);
    chk("single_rd_cs", 32'(ram_cs), 32'd1);
    step();
    idle();
    chk("single_rd_valid", 32'(rv[0]), 32'd1);
    chk("single_rd_data", rd[0], 32'hDEADBEEF);
    step();

    // Byte write then read back on m1.
    set_req(1, 1'b1, 32'h8, 4'b0010, 32'h0000AB00);
    step();
    idle();
    chk("bwr_ack_valid", 32'(rv[1]), 32'd1);
    chk("bwr_ack_data", rd[1], 32'h0);
    set_req(1, 1'b0, 32'h8, 4'h0, 32'h0);
    step();
    idle();
    chk("bwr_readback", rd[1], 32'h1122AB44);
    step();

    // Contention and backpressure table, fresh from reset.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idle();
      if (tbl[i].v0) set_req(0, 1'b0, 32'h14, 4'h0, 32'h0);
      if (tbl[i].v1) set_req(1, 1'b0, 32'h08, 4'h0, 32'h0);
      rr[0] = tbl[i].rr0;
      rr[1] = tbl[i].rr1;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'({rdy[1], rdy[0]}), 32'(tbl[i].gnt));
      if (i == 5) held = rd[0];
      if (i == 8) begin
        chk("bp_hold_data", rd[0], 32'hDEADBEEF);
        chk("bp_hold_same", rd[0], held);
        chk("bp_hold_valid", 32'(rv[0]), 32'd1);
      end
      step();
    end
    idle();
    step();

    // Reset mid-operation: m1 holds a response, prio left pointing at m1.
    set_req(0, 1'b0, 32'h14, 4'h0, 32'h0);
    step();
    idle();
    rr[1] = 1'b0;
    set_req(1, 1'b0, 32'h08, 4'h0, 32'h0);
    step();
    v[1] = 1'b0;
    set_req(0, 1'b0, 32'h14, 4'h0, 32'h0);
    step();
    set_req(1, 1'b0, 32'h08, 4'h0, 32'h0);
    chk("pre_rst_m1_valid", 32'(rv[1]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rv[1]), 32'd0);
    chk("async_rst_data", rd[1], 32'd0);
    chk("async_rst_cs", 32'(ram_cs), 32'd0);
    chk("async_rst_ready", 32'(rdy[0]), 32'd0);
    model_reset();
    @(negedge clk);
    step();
    rst_n = 1'b1;
    rr[0] = 1'b1;
    rr[1] = 1'b1;
    #1;
    chk("post_rst_first_gnt", 32'({rdy[1], rdy[0]}), 32'b01);
    step();
    idle();
    step();

    // Write from m1 followed next cycle by a read of the same word on m0.
    set_req(1, 1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
    step();
    idle();
    set_req(0, 1'b0, 32'h40, 4'h0, 32'h0);
    step();
    idle();
    chk("wr_rd_order", rd[0], 32'hCAFEF00D);
    step();

    // Randomized traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]  = ($urandom % 4) != 0;
        we[k] = 1'($urandom % 2);
        ad[k] = {22'd0, 8'($urandom_range(0, 31)), 2'($urandom)};
        wm[k] = 4'($urandom);
        wd[k] = $urandom;
        rr[k] = ($urandom % 4) != 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
